// File: rtl/bcd_conv_scheduler.sv
// Round-robin arbiter that shares one binary-to-BCD converter between two requesters.
// Results are held per requester; a watchdog aborts a conversion whose ready never arrives.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no conversion in flight; arbitrate pending requests
// ST_ISSUE | conv_en high for one cycle; operand already on conv_bin
// ST_WAIT  | waiting for conv_rdy (first cycle blanked) or watchdog
module bcd_conv_scheduler #(
    parameter int BIN_W   = 12,
    parameter int BCD_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [BIN_W-1:0] bin_a,
    input  logic [BIN_W-1:0] bin_b,
    output logic [1:0]       done,
    output logic [1:0]       err,
    output logic [BCD_W-1:0] bcd_a,
    output logic [BCD_W-1:0] bcd_b,
    output logic             busy,
    output logic             conv_en,
    output logic [BIN_W-1:0] conv_bin,
    input  logic [BCD_W-1:0] conv_bcd,
    input  logic             conv_rdy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int           TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic          grant;
    logic          last_grant;
    logic          g_sel;
    logic          blank;
    logic          rdy_ok;
    logic          expired;

    // Both requesting: hand the converter to whoever was not served last.
    assign g_sel   = (req == 2'b11) ? ~last_grant : req[1];

    // Watchdog counts down from TIMEOUT-1; the loaded value marks the blanking cycle.
    assign blank   = (timer == TO_LOAD);
    assign rdy_ok  = conv_rdy && !blank;
    assign expired = (timer == '0);

    assign busy    = (state != ST_IDLE);
    assign conv_en = (state == ST_ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            conv_bin   <= '0;
            bcd_a      <= '0;
            bcd_b      <= '0;
            done       <= 2'b00;
            err        <= 2'b00;
        end else begin
            done <= 2'b00;
            err  <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant    <= g_sel;
                        conv_bin <= g_sel ? bin_b : bin_a;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= TO_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rdy_ok) begin
                        if (grant) begin
                            bcd_b <= conv_bcd;
                        end else begin
                            bcd_a <= conv_bcd;
                        end
                        done       <= grant ? 2'b10 : 2'b01;
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end else if (expired) begin
                        err        <= grant ? 2'b10 : 2'b01;
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler with a behavioural converter whose
// ready delay, stuck-ready and never-ready modes are set per test.
module tb_bcd_conv_scheduler;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [11:0] bin_a = '0;
    logic [11:0] bin_b = '0;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] bcd_a;
    logic [15:0] bcd_b;
    logic        busy;
    logic        conv_en;
    logic [11:0] conv_bin;
    logic [15:0] conv_bcd = '0;
    logic        conv_rdy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int ev_cnt   = 0;
    int onehot_viol = 0;

    int          m_delay = 2;
    int          m_cnt   = 0;
    bit          m_pend  = 0;
    bit          m_stuck = 0;
    bit          m_never = 0;
    logic [11:0] m_bin   = '0;

    bcd_conv_scheduler #(.BIN_W(12), .BCD_W(16), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .bin_a    (bin_a),
        .bin_b    (bin_b),
        .done     (done),
        .err      (err),
        .bcd_a    (bcd_a),
        .bcd_b    (bcd_b),
        .busy     (busy),
        .conv_en  (conv_en),
        .conv_bin (conv_bin),
        .conv_bcd (conv_bcd),
        .conv_rdy (conv_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bin2bcd(input logic [11:0] v);
        logic [15:0] r;
        int x;
        r = '0;
        x = int'(v);
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Converter model and pulse monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (conv_en) begin
            en_cnt = en_cnt + 1;
            m_cnt  = m_delay;
            m_pend = 1;
            m_bin  = conv_bin;
            if (!m_stuck) conv_rdy = 1'b0;
        end else if (m_pend && !m_never) begin
            m_cnt = m_cnt - 1;
            if (m_cnt <= 0) begin
                conv_rdy = 1'b1;
                conv_bcd = bin2bcd(m_bin);
                m_pend   = 0;
            end
        end
        if ((done | err) != 2'b00) ev_cnt = ev_cnt + 1;
        if ($countones(done | err) > 1) onehot_viol = onehot_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_wait(output int n, output logic [1:0] d, output logic [1:0] e);
        n = 0;
        d = 2'b00;
        e = 2'b00;
        while (n < 200) begin
            tick();
            n = n + 1;
            if ((done | err) != 2'b00) begin
                d = done;
                e = err;
                return;
            end
        end
        check("wait_bound", {30'b0, done | err}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int          n;
    logic [1:0]  d;
    logic [1:0]  e;
    int          e0;
    int          ev0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_en", conv_en, 0);
        check("rst_bcd_a", bcd_a, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // single request, slow converter
        bin_a = 12'd255; req = 2'b01; m_delay = 14; e0 = en_cnt;
        tick();
        check("t1_en", conv_en, 1);
        check("t1_bin", conv_bin, 255);
        check("t1_busy", busy, 1);
        req = 2'b00;
        run_wait(n, d, e);
        check("t1_lat", n, 15);
        check("t1_done", d, 2'b01);
        check("t1_err", e, 2'b00);
        check("t1_bcd_a", bcd_a, 16'h0255);
        tick();
        check("t1_pulse", done, 0);
        check("t1_idle", busy, 0);
        check("t1_en_cnt", en_cnt - e0, 1);

        // both requesting from reset: requester 0 first
        do_reset();
        bin_a = 12'd9; bin_b = 12'd4095; req = 2'b11; m_delay = 2;
        tick();
        check("t2_bin0", conv_bin, 9);
        run_wait(n, d, e);
        check("t2_lat", n, 3);
        check("t2_done0", d, 2'b01);
        check("t2_bcd_a", bcd_a, 16'h0009);
        req = 2'b10;
        tick();
        check("t2_bin1", conv_bin, 4095);
        run_wait(n, d, e);
        check("t2_done1", d, 2'b10);
        check("t2_bcd_b", bcd_b, 16'h4095);

        // fairness under sustained contention
        bin_a = 12'd123; bin_b = 12'd7; req = 2'b11; m_delay = 3;
        for (int k = 0; k < 6; k++) begin
            run_wait(n, d, e);
            check("t3_order", d, (k % 2 == 1) ? 2'b10 : 2'b01);
            check("t3_lat", n, 5);
        end
        req = 2'b00;
        check("t3_bcd_a", bcd_a, 16'h0123);
        check("t3_bcd_b", bcd_b, 16'h0007);

        // watchdog timeout, then grant passes to requester 1
        tick();
        m_never = 1; bin_a = 12'd42; req = 2'b01;
        tick();
        check("t4_bin", conv_bin, 42);
        run_wait(n, d, e);
        check("t4_lat", n, TO + 1);
        check("t4_err", e, 2'b01);
        check("t4_done", d, 2'b00);
        check("t4_bcd_a", bcd_a, 16'h0123);
        req = 2'b11; bin_b = 12'd321; m_never = 0; m_pend = 0; m_delay = 2;
        tick();
        check("t4_next_grant", conv_bin, 321);
        req = 2'b00;
        run_wait(n, d, e);
        check("t4_done1", d, 2'b10);
        check("t4_bcd_b", bcd_b, 16'h0321);

        // ready stuck high across ISSUE: blanking cycle must ignore it
        tick();
        m_stuck = 1; bin_a = 12'd777; req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        check("t5_blank", done, 0);
        tick();
        check("t5_early", done, 0);
        tick();
        check("t5_done", done, 2'b01);
        check("t5_bcd_a", bcd_a, 16'h0777);
        m_stuck = 0;

        // asynchronous reset in the middle of WAIT
        tick();
        bin_a = 12'd500; req = 2'b01; m_delay = 10;
        tick();
        req = 2'b00;
        repeat (3) tick();
        ev0 = ev_cnt;
        #2 reset = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_bcd_a", bcd_a, 0);
        check("t6_bcd_b", bcd_b, 0);
        check("t6_bin", conv_bin, 0);
        repeat (3) tick();
        reset = 1'b0;
        bin_a = 12'd8; bin_b = 12'd56; req = 2'b11; m_delay = 2;
        tick();
        check("t6_no_event", ev_cnt - ev0, 0);
        check("t6_first_grant", conv_bin, 8);
        req = 2'b10;
        run_wait(n, d, e);
        check("t6_done0", d, 2'b01);
        check("t6_bcd_a8", bcd_a, 16'h0008);
        tick();
        check("t6_second_grant", conv_bin, 56);
        req = 2'b00;
        run_wait(n, d, e);
        check("t6_done1", d, 2'b10);
        check("t6_bcd_b56", bcd_b, 16'h0056);

        check("onehot_done_err", onehot_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
